// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - port bundle for the multi-port register file
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     link_en;
    logic [DATA_W-1:0]        link_data;
    logic                     claim_en;
    logic [ADDR_W-1:0]        claim_addr;
    logic [DATA_W-1:0]        tap_v0;
    logic [DATA_W-1:0]        tap_a0;
    logic [DATA_W-1:0]        tap_ra;
    logic [DATA_W-1:0]        tap_sp;

    modport master (
        output rd_en, rd_addr, wb_en, wb_addr, wb_data, link_en, link_data, claim_en, claim_addr,
        input  rd_data, rd_busy, tap_v0, tap_a0, tap_ra, tap_sp
    );

    modport slave (
        input  rd_en, rd_addr, wb_en, wb_addr, wb_data, link_en, link_data, claim_en, claim_addr,
        output rd_data, rd_busy, tap_v0, tap_a0, tap_ra, tap_sp
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard and taps; optional REGFILE_BYPASS_EN
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = 31,
    parameter int TAP_V0   = 2,
    parameter int TAP_A0   = 4,
    parameter int TAP_SP   = 29
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A   = '0;
    localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] V0_A     = ADDR_W'(TAP_V0);
    localparam logic [ADDR_W-1:0] A0_A     = ADDR_W'(TAP_A0);
    localparam logic [ADDR_W-1:0] SP_A     = ADDR_W'(TAP_SP);

    logic [DATA_W-1:0]        mem [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q;
    logic [NUM_REGS-1:0]      busy_d;
    logic                     link_we;
    logic                     wb_we;
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q;
    logic [NUM_RD-1:0]        rd_busy_d;
    logic [ADDR_W-1:0]        ra;
    logic [DATA_W-1:0]        rv;

    // Qualify writes: r0 is never written and link beats wb on LINK_REG
    always_comb begin
        link_we = bus.link_en && (LINK_A != ZERO_A);
        wb_we   = bus.wb_en && (bus.wb_addr != ZERO_A) && !(link_we && (bus.wb_addr == LINK_A));
    end

    // Next scoreboard state: clears first, then a claim overrides on the same register
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_en) begin
            busy_d[bus.wb_addr] = 1'b0;
        end
        if (bus.link_en) begin
            busy_d[LINK_A] = 1'b0;
        end
        if (bus.claim_en) begin
            busy_d[bus.claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Per-port read value; disabled ports keep their last sample
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        ra        = '0;
        rv        = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (bus.rd_en[k]) begin
                ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
                rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (link_we && (ra == LINK_A)) begin
                    rv = bus.link_data;
                end else if (wb_we && (ra == bus.wb_addr)) begin
                    rv = bus.wb_data;
                end
`endif
                if (ra == ZERO_A) begin
                    rv = '0;
                end
                rd_data_d[k*DATA_W +: DATA_W] = rv;
                rd_busy_d[k]                  = busy_d[ra];
            end
        end
    end

    // Register array commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wb_we) begin
                mem[bus.wb_addr] <= bus.wb_data;
            end
            if (link_we) begin
                mem[LINK_A] <= bus.link_data;
            end
        end
    end

    // Scoreboard and read port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_busy = rd_busy_q;
    assign bus.tap_v0  = mem[V0_A];
    assign bus.tap_a0  = mem[A0_A];
    assign bus.tap_ra  = mem[LINK_A];
    assign bus.tap_sp  = mem[SP_A];
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined MIPS core, replacing the fixed two-read/one-write file. It provides NUM_RD registered read ports, a writeback port plus a dedicated link port for JAL, a per-register busy scoreboard for hazard detection, and fixed-index taps for the syscall and JR logic. It sits between decode (reads, claims, link writes) and writeback (data writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- LINK_REG, 31, index written by the link port
- TAP_V0 / TAP_A0 / TAP_SP, 2 / 4 / 29, tap indices

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_busy  out  NUM_RD  registered scoreboard bit of the address read
- wb_en, wb_addr, wb_data  in  1, ADDR_W, DATA_W  writeback write
- link_en, link_data  in  1, DATA_W  link write to LINK_REG
- claim_en, claim_addr  in  1, ADDR_W  mark a register as pending a write
- tap_v0, tap_a0, tap_ra, tap_sp  out  DATA_W each  current contents of TAP_V0, TAP_A0, LINK_REG, TAP_SP

## Operation
- Register 0 reads as 0 at all times. Writes to it are dropped, and claims on it are ignored, so busy[0] is always 0.
- Writes commit on posedge clk.
- When both write ports target LINK_REG in the same cycle, the link port wins. A wb write to any other address proceeds normally in the same cycle.
- Reads: on posedge clk with rd_en[k]=1, port k samples rd_data and rd_busy from rd_addr[k]. With rd_en[k]=0, port k holds its outputs.
- Scoreboard, one bit per register:
  - claim_en sets the bit for claim_addr.
  - A wb write clears the bit for wb_addr.
  - A link write clears the bit for LINK_REG.
  - If a claim and a clear hit the same address in the same cycle, the claim wins and the bit stays 1.
- Taps are combinational from the array and reflect committed state only. Taps never bypass.
- Reset (rst_n=0, any time, including mid-operation):
  - every register, busy bit, rd_data and rd_busy goes to 0;
  - taps read 0;
  - writes, claims and reads issued in the reset cycle are discarded.

## Timing
- Read latency is 1 cycle: address presented at edge N, data valid after edge N.
- Write-to-tap latency: the value is visible after the commit edge.
- Same-cycle write and read of the same address: the result depends on the configuration macro below.
- Same-cycle clear and read of the same address: rd_busy returns the post-update bit (0 unless a claim also hits that address).
- Deassertion of rst_n is assumed synchronised externally. The first active edge is the first edge with rst_n=1.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: a read of address A at edge N while a write to A also commits at edge N returns the new data. Link has priority if both write ports target A. Address 0 still returns 0.
- Not defined: that read returns the pre-write value, and the new value appears on the next read.
- Busy bypass (post-update bit) is always on, independent of the macro.

## Test plan
- Reset mid-run: fill r1..r31 with their index, claim r8, pulse rst_n low between edges -> immediately all taps = 0, rd_data = 0, rd_busy = 0; read r8 afterward -> data 0, busy 0.
- Write/read same cycle: wb r5 = 0xDEADBEEF with port 0 reading r5 -> rd_data = 0xDEADBEEF when REGFILE_BYPASS_EN is defined, 0x00000000 when not; next read returns 0xDEADBEEF in both builds.
- Link collision: link_data = 0x00400010 and wb to r31 = 0x1234 on the same edge -> tap_ra = 0x00400010. Repeat with wb to r7 -> both r7 and r31 are written.
- Zero register: wb r0 = 0xFFFFFFFF with claim r0 -> reading r0 gives data 0, busy 0.
- Scoreboard: claim r9 -> next read rd_busy = 1; wb r9 = 7 -> rd_busy = 0, data 7. Claim r9 and wb r9 on the same edge -> busy stays 1.
- NUM_RD=4, DATA_W=16: read four distinct addresses in one cycle -> each packed lane holds its own value. A lane with rd_en=0 holds its previous value.
